// File: rtl/program_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic              abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_hold;
  logic              pc_clear;
  logic              busy;

  modport master (
    input  start, abort, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_hold, pc_clear, busy
  );

  modport slave (
    output start, abort, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, pc_clear, busy
  );
endinterface

// File: rtl/program_loader.sv
// Loads a header-prefixed byte stream into instruction memory as 16-bit words,
// holding the CPU while loading and pulsing pc_clear once the load completes.
module program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.master  bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HI, S_LO, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              xfer_c;

  // An aborted cycle never counts as a transfer.
  assign xfer_c = bus.byte_valid & ready_q & ~bus.abort;

  assign bus.byte_ready = ready_q;
  assign bus.im_we      = we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.pc_clear   = clr_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      hold_q   <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
    end
  end

  // Next state and datapath; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: if (bus.start) state_d = S_HDR;
      S_HDR: if (xfer_c) begin
        // Header 0 encodes a full memory of 2**ADDR_W words.
        target_d = (bus.byte_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(bus.byte_data);
        cnt_d    = '0;
        addr_d   = '0;
        state_d  = S_HI;
      end
      S_HI: if (xfer_c) begin
        hi_d    = bus.byte_data;
        state_d = S_LO;
      end
      S_LO: if (xfer_c) begin
        wdata_d = DATA_W'({hi_q, bus.byte_data});
        state_d = S_WR;
      end
      S_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q + CNT_W'(1) == target_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_HI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) state_d = S_IDLE;

    ready_d = (state_d == S_HDR) || (state_d == S_HI) || (state_d == S_LO);
    we_d    = (state_d == S_WR);
    clr_d   = (state_d == S_DONE);
    hold_d  = (state_d != S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end
endmodule
